// File: rtl/hazard_stall_controller_if.sv
// Control bundle between the pipeline datapath and the stall/flush sequencer.
// The slave side is the sequencer; the master side is the datapath.
interface hazard_stall_controller_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             IDRs;
  logic [4:0]             IDRt;
  logic                   IDUsesRt;
  logic                   EXMemRead;
  logic [4:0]             EXRt;
  logic                   EXMulDivStart;
  logic                   IDBranchTaken;
  logic                   PCWrite;
  logic                   IFIDWrite;
  logic                   IFIDFlush;
  logic                   IDEXWrite;
  logic                   IDEXBubble;
  logic                   EXMEMBubble;
  logic                   MDBusy;
  logic                   MDDone;
  logic [STALL_CNT_W-1:0] StallCount;

  modport slave (
    input  IDRs, IDRt, IDUsesRt, EXMemRead, EXRt, EXMulDivStart, IDBranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble,
           MDBusy, MDDone, StallCount
  );

  modport master (
    output IDRs, IDRt, IDUsesRt, EXMemRead, EXRt, EXMulDivStart, IDBranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble,
           MDBusy, MDDone, StallCount
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// squash in ID and front-end hold while a multi-cycle mult/div occupies EX.
module hazard_stall_controller #(
  parameter int MD_LATENCY  = 4,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_next_cnt;
  logic [STALL_CNT_W-1:0] r_stall_count;
  logic                   w_lu;

  // ALU-to-ALU dependencies are the forwarding unit's job; only a load in EX stalls.
  assign w_lu = bus.EXMemRead && (bus.EXRt != 5'd0) &&
                ((bus.EXRt == bus.IDRs) || (bus.IDUsesRt && (bus.EXRt == bus.IDRt)));

  always_comb begin
    bus.PCWrite     = 1'b1;
    bus.IFIDWrite   = 1'b1;
    bus.IFIDFlush   = 1'b0;
    bus.IDEXWrite   = 1'b1;
    bus.IDEXBubble  = 1'b0;
    bus.EXMEMBubble = 1'b0;
    bus.MDBusy      = 1'b0;
    bus.MDDone      = 1'b0;
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;

    case (r_state)
      RUN: begin
        if (bus.EXMulDivStart) begin
          bus.MDBusy = 1'b1;
          if (MD_LATENCY > 1) begin
            bus.PCWrite     = 1'b0;
            bus.IFIDWrite   = 1'b0;
            bus.IDEXWrite   = 1'b0;
            bus.EXMEMBubble = 1'b1;
            w_next_state    = MD_BUSY;
            w_next_cnt      = CNT_W'(MD_LATENCY - 2);
          end else begin
            bus.MDDone = 1'b1;
          end
        end else if (w_lu) begin
          // Branch is re-resolved next cycle with forwarded data, so no flush yet.
          bus.PCWrite    = 1'b0;
          bus.IFIDWrite  = 1'b0;
          bus.IDEXBubble = 1'b1;
        end else if (bus.IDBranchTaken) begin
          bus.IFIDFlush = 1'b1;
        end
      end
      MD_BUSY: begin
        bus.MDBusy = 1'b1;
        if (r_cnt != '0) begin
          bus.PCWrite     = 1'b0;
          bus.IFIDWrite   = 1'b0;
          bus.IDEXWrite   = 1'b0;
          bus.EXMEMBubble = 1'b1;
          w_next_cnt      = r_cnt - 1'b1;
        end else begin
          bus.MDDone   = 1'b1;
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase

    if (!rst) begin
      bus.PCWrite     = 1'b0;
      bus.IFIDWrite   = 1'b0;
      bus.IFIDFlush   = 1'b0;
      bus.IDEXWrite   = 1'b0;
      bus.IDEXBubble  = 1'b1;
      bus.EXMEMBubble = 1'b1;
      bus.MDBusy      = 1'b0;
      bus.MDDone      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (!bus.PCWrite && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: a full-width instance and a 4-bit-counter instance share
// the same stimulus; expected outputs are queued per cycle and checked at negedge.
module tb_hazard_stall_controller;

  localparam logic [7:0] IDLE = 8'hD0;  // {PC,IFIDW,FLUSH,IDEXW,IDEXB,EXMEMB,BUSY,DONE}
  localparam logic [7:0] RSTV = 8'h0C;
  localparam logic [7:0] LUST = 8'h18;
  localparam logic [7:0] BRFL = 8'hF0;
  localparam logic [7:0] MDST = 8'h06;
  localparam logic [7:0] MDDN = 8'hD3;

  typedef struct packed {
    logic [7:0]  outs;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } sb_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  sb_t  sb[$];
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt_s;
  logic [7:0]  w_out_a;
  logic [7:0]  w_out_s;

  hazard_stall_controller_if #(.STALL_CNT_W(16)) bus_a ();
  hazard_stall_controller_if #(.STALL_CNT_W(4))  bus_s ();

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(4), .STALL_CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(4), .STALL_CNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  assign bus_s.IDRs          = bus_a.IDRs;
  assign bus_s.IDRt          = bus_a.IDRt;
  assign bus_s.IDUsesRt      = bus_a.IDUsesRt;
  assign bus_s.EXMemRead     = bus_a.EXMemRead;
  assign bus_s.EXRt          = bus_a.EXRt;
  assign bus_s.EXMulDivStart = bus_a.EXMulDivStart;
  assign bus_s.IDBranchTaken = bus_a.IDBranchTaken;

  assign w_out_a = {bus_a.PCWrite, bus_a.IFIDWrite, bus_a.IFIDFlush, bus_a.IDEXWrite,
                    bus_a.IDEXBubble, bus_a.EXMEMBubble, bus_a.MDBusy, bus_a.MDDone};
  assign w_out_s = {bus_s.PCWrite, bus_s.IFIDWrite, bus_s.IFIDFlush, bus_s.IDEXWrite,
                    bus_s.IDEXBubble, bus_s.EXMEMBubble, bus_s.MDBusy, bus_s.MDDone};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic mr,
                      input logic [4:0] ert, input logic md, input logic br,
                      input logic [7:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus_a.IDRs          = rs;
    bus_a.IDRt          = rt;
    bus_a.IDUsesRt      = urt;
    bus_a.EXMemRead     = mr;
    bus_a.EXRt          = ert;
    bus_a.EXMulDivStart = md;
    bus_a.IDBranchTaken = br;
    if (!r) begin
      exp_cnt   = '0;
      exp_cnt_s = '0;
    end
    e.outs  = exp;
    e.cnt   = exp_cnt;
    e.cnt_s = exp_cnt_s;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".outs"}, {24'd0, w_out_a}, {24'd0, e.outs});
    chk({tag, ".outs_s"}, {24'd0, w_out_s}, {24'd0, e.outs});
    chk({tag, ".cnt"}, {16'd0, bus_a.StallCount}, {16'd0, e.cnt});
    chk({tag, ".cnt_s"}, {28'd0, bus_s.StallCount}, {28'd0, e.cnt_s});
    $display("step %-10s rst=%0b outs=%02h cnt=%0d cnt_s=%0d", tag, r, w_out_a,
             bus_a.StallCount, bus_s.StallCount);
    // Next rising edge counts a stall if the front end is held out of reset.
    if (r && !exp[7]) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
      if (exp_cnt_s != 4'hF) exp_cnt_s = exp_cnt_s + 1'b1;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_cnt   = '0;
    exp_cnt_s = '0;
    rst       = 1'b0;
    bus_a.IDRs = 5'd0; bus_a.IDRt = 5'd0; bus_a.IDUsesRt = 1'b0; bus_a.EXMemRead = 1'b0;
    bus_a.EXRt = 5'd0; bus_a.EXMulDivStart = 1'b0; bus_a.IDBranchTaken = 1'b0;

    // Reset while a load-use hazard and a taken branch are presented
    for (int i = 0; i < 3; i++) step("reset", 0, 5'd8, 5'd8, 1, 1, 5'd8, 0, 1, RSTV);
    step("idle", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, IDLE);

    // Load-use on rs, r0 destination, non-matching register
    step("lu_rs", 1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, LUST);
    step("lu_after", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, IDLE);
    step("lu_r0", 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, IDLE);
    step("lu_nomatch", 1, 5'd3, 5'd4, 1, 1, 5'd8, 0, 0, IDLE);

    // rt dependency gated by IDUsesRt; branch flush suppressed under LU
    step("rt_unused", 1, 5'd1, 5'd9, 0, 1, 5'd9, 0, 0, IDLE);
    step("rt_used", 1, 5'd1, 5'd9, 1, 1, 5'd9, 0, 0, LUST);
    step("rt_br", 1, 5'd1, 5'd9, 1, 1, 5'd9, 0, 1, LUST);
    step("br_only", 1, 5'd1, 5'd9, 1, 0, 5'd9, 0, 1, BRFL);
    step("alu_dep", 1, 5'd9, 5'd9, 1, 0, 5'd9, 0, 0, IDLE);

    // Mult/div with hazards injected during the hold and done cycles
    step("rst_md", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RSTV);
    step("md_s0", 1, 5'd8, 5'd0, 0, 1, 5'd8, 1, 1, MDST);
    step("md_s1", 1, 5'd8, 5'd0, 0, 1, 5'd8, 1, 1, MDST);
    step("md_s2", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, MDST);
    step("md_done", 1, 5'd8, 5'd0, 0, 1, 5'd8, 1, 1, MDDN);
    step("md_after", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, IDLE);

    // Reset in the second MD_BUSY cycle aborts; a full sequence restarts
    step("ab_s0", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MDST);
    step("ab_s1", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MDST);
    step("ab_rst", 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, RSTV);
    step("re_s0", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MDST);
    step("re_s1", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MDST);
    step("re_s2", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MDST);
    step("re_done", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, MDDN);
    step("re_after", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, BRFL);

    // Saturation of the 4-bit counter over 20 stall cycles
    step("rst_sat", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RSTV);
    for (int i = 0; i < 20; i++) step("sat_lu", 1, 5'd7, 5'd0, 0, 1, 5'd7, 0, 0, LUST);
    step("sat_hold", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, BRFL);
    chk("sat_final_s", {28'd0, bus_s.StallCount}, 32'd15);
    chk("sat_final_a", {16'd0, bus_a.StallCount}, 32'd20);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
